// File: rtl/dgldpc_pkg.sv
// dgldpc_pkg
// Shared definitions for the shuffled DG-LDPC decoder datapath.
//   LLR_W            : check-to-variable message width, sign bit included
//   llr_t            : one message word
//   LLR_SIGN_IDX     : sign bit position of a sign-magnitude word
//   LLR_MAG_MSB/LSB  : magnitude field bounds of a sign-magnitude word
//   FRM_CNT_W        : width of frame / statistics counters
package dgldpc_pkg;

  localparam int LLR_W        = 11;
  typedef logic [LLR_W-1:0] llr_t;

  localparam int LLR_SIGN_IDX = LLR_W - 1;
  localparam int LLR_MAG_MSB  = LLR_W - 2;
  localparam int LLR_MAG_LSB  = 0;

  localparam int FRM_CNT_W    = 16;

endpackage

// File: rtl/sm2compl_conv.sv
// sm2compl_conv
// Pure combinational sign-magnitude to two's-complement converter.
// Negative zero maps to all-zeros, so the result never reaches -2^(W-1).
// Ports:
//   i_sm : W-bit sign-magnitude word (bit W-1 = sign)
//   o_tc : W-bit two's-complement word
module sm2compl_conv
  import dgldpc_pkg::*;
#(
  parameter int W = LLR_W
) (
  input  logic [W-1:0] i_sm,
  output logic [W-1:0] o_tc
);

  logic         w_sign;
  logic [W-1:0] w_mag_ext;

  assign w_sign    = i_sm[W-1];
  assign w_mag_ext = {1'b0, i_sm[W-2:0]};

  // Negating a zero-extended magnitude: ~0 + 1 wraps to 0, which is what
  // folds negative zero onto positive zero.
  assign o_tc = w_sign ? (~w_mag_ext + {{(W-1){1'b0}}, 1'b1}) : w_mag_ext;

endmodule

// File: rtl/sm2compl_pipe.sv
// sm2compl_pipe
// Two-stage streaming sign-magnitude to two's-complement converter with a
// frame counter that flags the N_MSG-th word of each frame.
// Stage 1 holds the raw word and its last flag, stage 2 the converted word.
// Optional feature macro: SM2COMPL_NZ_CNT_EN adds o_nz_cnt, a saturating
// per-frame count of accepted negative-zero inputs.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid/o_ready/i_data : upstream handshake and sign-magnitude word
//   o_valid/i_ready/o_data/o_last : downstream handshake, converted word,
//                                   end-of-frame marker
//   o_nz_cnt : negative-zero count (SM2COMPL_NZ_CNT_EN only)
module sm2compl_pipe
  import dgldpc_pkg::*;
#(
  parameter int W     = LLR_W,
  parameter int N_MSG = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  input  logic         i_ready
`ifdef SM2COMPL_NZ_CNT_EN
  ,
  output logic [FRM_CNT_W-1:0] o_nz_cnt
`endif
);

  localparam logic [FRM_CNT_W-1:0] CNT_LAST = FRM_CNT_W'(N_MSG - 1);

  logic                 r_s1_v;
  logic [W-1:0]         r_s1_data;
  logic                 r_s1_last;
  logic                 r_s2_v;
  logic [W-1:0]         r_s2_data;
  logic                 r_s2_last;
  logic [FRM_CNT_W-1:0] r_frm_cnt;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic                 w_accept;
  logic                 w_cnt_at_last;
  logic [W-1:0]         w_conv;

  // Ready depends only on registered valids plus i_ready, so a returning
  // i_ready reopens the input in the same cycle.
  assign w_s2_adv      = !r_s2_v || i_ready;
  assign w_s1_adv      = !r_s1_v || w_s2_adv;
  assign w_accept      = i_valid && w_s1_adv;
  assign w_cnt_at_last = (r_frm_cnt == CNT_LAST);

  assign o_ready = w_s1_adv;
  assign o_valid = r_s2_v;
  assign o_data  = r_s2_data;
  assign o_last  = r_s2_v && r_s2_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frm_cnt <= '0;
    end else if (w_accept) begin
      r_frm_cnt <= w_cnt_at_last ? '0 : r_frm_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_last <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_data <= i_data;
        r_s1_last <= w_cnt_at_last;
      end
    end
  end

  sm2compl_conv #(
    .W (W)
  ) u_conv (
    .i_sm (r_s1_data),
    .o_tc (w_conv)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_last <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_data <= w_conv;
        r_s2_last <= r_s1_last;
      end
    end
  end

`ifdef SM2COMPL_NZ_CNT_EN
  logic                 w_is_nz;
  logic                 w_frm_first;
  logic [FRM_CNT_W-1:0] r_nz_cnt;

  assign w_is_nz     = (i_data == {1'b1, {(W-1){1'b0}}});
  assign w_frm_first = (r_frm_cnt == '0);

  // The first word of a frame restarts the count, including itself.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nz_cnt <= '0;
    end else if (w_accept) begin
      if (w_frm_first) begin
        r_nz_cnt <= {{(FRM_CNT_W-1){1'b0}}, w_is_nz};
      end else if (w_is_nz && (r_nz_cnt != {FRM_CNT_W{1'b1}})) begin
        r_nz_cnt <= r_nz_cnt + 1'b1;
      end
    end
  end

  assign o_nz_cnt = r_nz_cnt;
`else
  // Negative-zero statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_sm2compl_pipe.sv
module tb_sm2compl_pipe;
  import dgldpc_pkg::*;

  localparam int NF = 4;

  typedef struct packed {
    llr_t d;
    logic l;
  } exp_t;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic i_valid = 1'b0;
  logic i_ready = 1'b1;
  llr_t i_data  = '0;

  logic o_ready, o_valid, o_last;
  llr_t o_data;
  logic o_ready1, o_valid1, o_last1;
  llr_t o_data1;
`ifdef SM2COMPL_NZ_CNT_EN
  logic [15:0] o_nz_cnt, o_nz_cnt1;
`endif

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_cnt  = 0;
  int   m_nz   = 0;
  bit   rnd_done = 0;

  always #5 clk = ~clk;

  sm2compl_pipe #(.W(LLR_W), .N_MSG(NF)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_last  (o_last),
    .i_ready (i_ready)
`ifdef SM2COMPL_NZ_CNT_EN
    ,
    .o_nz_cnt(o_nz_cnt)
`endif
  );

  sm2compl_pipe #(.W(LLR_W), .N_MSG(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready1),
    .o_valid (o_valid1),
    .o_data  (o_data1),
    .o_last  (o_last1),
    .i_ready (i_ready)
`ifdef SM2COMPL_NZ_CNT_EN
    ,
    .o_nz_cnt(o_nz_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic llr_t ref_conv(input llr_t d);
    int mag;
    int v;
    mag = int'(d[LLR_MAG_MSB:LLR_MAG_LSB]);
    v   = d[LLR_SIGN_IDX] ? -mag : mag;
    return llr_t'(v);
  endfunction

  task automatic push_exp(input llr_t d, input llr_t e);
    exp_t t;
    bit   nz;
    t.d = e;
    t.l = (m_cnt == NF - 1);
    q.push_back(t);
    nz = (d == 11'h400);
    if (m_cnt == 0) m_nz = nz ? 1 : 0;
    else if (nz && m_nz != 16'hFFFF) m_nz++;
    m_cnt = (m_cnt == NF - 1) ? 0 : m_cnt + 1;
  endtask

  // Holds i_valid until the word is accepted; returns #1 after the accept edge.
  task automatic send(input llr_t d, input llr_t e);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_data  = d;
    forever begin
      @(negedge clk);
      if (o_ready) begin
        push_exp(d, e);
        @(posedge clk); #1;
`ifdef SM2COMPL_NZ_CNT_EN
        chk("nz_cnt", 32'(o_nz_cnt), 32'(m_nz));
`endif
        break;
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 2000) begin
        chk("send_timeout", 32'(guard), 0);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard   = 0;
    i_ready = 1'b1;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(q.size()), 0);
    chk("drain_valid", 32'(o_valid), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 0);
    chk("rst_o_data",  32'(o_data),  0);
    chk("rst_o_last",  32'(o_last),  0);
`ifdef SM2COMPL_NZ_CNT_EN
    chk("rst_nz_cnt",  32'(o_nz_cnt), 0);
`endif
    q.delete();
    m_cnt = 0;
    m_nz  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(o_ready), 1);
  endtask

  // Empty pipe, downstream stalled: exactly two words fit.
  task automatic absorb_two(input llr_t base);
    int acc;
    acc     = 0;
    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1;
      i_data  = base + llr_t'(acc);
      @(negedge clk);
      if (o_ready) begin
        push_exp(i_data, ref_conv(i_data));
        acc++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk("absorb_cnt", 32'(acc), 2);
    chk("stall_ready", 32'(o_ready), 0);
  endtask

  // Output monitor: scoreboard pop on transfer, stability while stalled,
  // and the N_MSG=1 instance tracks the main one with last on every word.
  initial begin
    exp_t e;
    bit   hold_pend;
    llr_t held_d;
    logic held_l;
    hold_pend = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pend = 0;
      end else begin
        if (hold_pend)
          chk("stall_hold", {20'd0, o_valid, o_data, o_last}, {20'd0, 1'b1, held_d, held_l});
        hold_pend = 0;
        if (o_valid) begin
          if (i_ready) begin
            if (q.size() == 0) begin
              chk("sb_underflow", 32'(q.size()), 1);
            end else begin
              e = q.pop_front();
              chk("data", 32'(o_data), 32'(e.d));
              chk("last", 32'(o_last), 32'(e.l));
            end
          end else begin
            hold_pend = 1;
            held_d    = o_data;
            held_l    = o_last;
          end
        end
        if (o_valid || o_valid1) begin
          chk("n1_valid", 32'(o_valid1), 32'(o_valid));
          chk("n1_data",  32'(o_data1),  32'(o_data));
          chk("n1_last",  32'(o_last1),  1);
        end
      end
    end
  end

  initial begin
    llr_t dir_in [5] = '{11'h005, 11'h405, 11'h7FF, 11'h3FF, 11'h400};
    llr_t dir_exp[5] = '{11'h005, 11'h7FB, 11'h401, 11'h3FF, 11'h000};
    llr_t bp_words[10] = '{11'h001, 11'h402, 11'h07F, 11'h4FF, 11'h200,
                           11'h600, 11'h400, 11'h3FE, 11'h7FE, 11'h011};

    do_reset();

    // Latency from accept edge on an idle pipe.
    send(11'h005, 11'h005);
    chk("lat_edge1_valid", 32'(o_valid), 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(o_valid), 1);
    chk("lat_edge2_data",  32'(o_data),  32'h005);

    for (int i = 0; i < 5; i++) send(dir_in[i], dir_exp[i]);
    drain();

    // Stall absorb, combinational ready return, then shift with full pipe.
    absorb_two(11'h410);
    i_ready = 1'b1;
    #1;
    chk("ready_comb", 32'(o_ready), 1);
    for (int i = 0; i < 4; i++) send(11'h020 + llr_t'(i), ref_conv(11'h020 + llr_t'(i)));
    drain();

    // Ten-word stream with downstream stalled for cycles 3..7.
    fork
      begin
        for (int i = 0; i < 10; i++) send(bp_words[i], ref_conv(bp_words[i]));
      end
      begin
        repeat (3) @(posedge clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();

    // Framing from a fresh frame: last on words 4 and 8 of 9.
    do_reset();
    for (int i = 0; i < 9; i++) send(11'h100 + llr_t'(i), ref_conv(11'h100 + llr_t'(i)));
    drain();

    // Reset with both stages full and the counter at 2.
    do_reset();
    absorb_two(11'h420);
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(11'h430 + llr_t'(i), ref_conv(11'h430 + llr_t'(i)));
    drain();

    // Random valid/ready toggling.
    rnd_done = 0;
    fork
      begin
        llr_t d;
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          d = llr_t'($urandom_range(0, 2047));
          if ($urandom_range(0, 15) == 0) d = 11'h400;
          send(d, ref_conv(d));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 i_ready = ($urandom_range(0, 9) < 7);
        end
        i_ready = 1'b1;
      end
    join
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
